// File: rtl/sm_clk_ctrl_pkg.sv
// Shared encodings and helpers for the run/step/breakpoint CPU clock controller.
package sm_clk_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'd0,
        MODE_RUN   = 2'd1,
        MODE_BURST = 2'd2,
        MODE_BRK   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        PH_OFF  = 2'd0,
        PH_HIGH = 2'd1,
        PH_LOW  = 2'd2
    } phase_e;

    // Half-period length in board clocks: 2^(shift + devide)
    function automatic logic [31:0] half_len(input logic [4:0] shift, input logic [3:0] dv);
        logic [5:0] e;
        e = {1'b0, shift} + {2'b00, dv};
        return 32'd1 << e;
    endfunction

endpackage

// File: rtl/sm_edge_detect.sv
// Registered-history rising-edge detector; rise is combinational against the previous sample.
module sm_edge_detect #(
    parameter int SIZE = 1
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [SIZE-1:0] d_i,
    output logic [SIZE-1:0] rise_o
);

    logic [SIZE-1:0] prev_q;

    // previous-sample register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prev_q <= '0;
        end else begin
            prev_q <= d_i;
        end
    end

    assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/sm_clk_ctrl.sv
// Sequenced CPU clock: whole cycles of programmable length with free run,
// single step, N-cycle bursts and a PC breakpoint, plus a completed-cycle counter.
module sm_clk_ctrl
    import sm_clk_ctrl_pkg::*;
#(
    parameter int SHIFT = 16,
    parameter int CNT_W = 32
) (
    input  logic             clkIn,
    input  logic             rst_n,
    input  logic [3:0]       devide,
    input  logic             run,
    input  logic             step,
    input  logic             burstGo,
    input  logic [7:0]       burstLen,
    input  logic             bpEnable,
    input  logic [31:0]      bpAddr,
    input  logic [31:0]      pc,
    output logic             clkOut,
    output logic [CNT_W-1:0] cycleCnt,
    output logic [1:0]       mode,
    output logic             bpHit
);

    localparam logic [4:0] SHIFT_W = 5'(SHIFT);

    logic step_rise_s, burst_rise_s, run_up_s;

    sm_edge_detect #(.SIZE(1)) u_step_ed  (.clk_i(clkIn), .rst_n_i(rst_n), .d_i(step),    .rise_o(step_rise_s));
    sm_edge_detect #(.SIZE(1)) u_burst_ed (.clk_i(clkIn), .rst_n_i(rst_n), .d_i(burstGo), .rise_o(burst_rise_s));
    sm_edge_detect #(.SIZE(1)) u_run_ed   (.clk_i(clkIn), .rst_n_i(rst_n), .d_i(run),     .rise_o(run_up_s));

    phase_e           phase_q, phase_d;
    mode_e            mode_q, mode_d;
    logic [31:0]      hcnt_q, hcnt_d;
    logic [31:0]      hlen_q, hlen_d;
    logic [7:0]       rem_q, rem_d;
    logic             mask_q, mask_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_out_q, bp_hit_q;
    logic             start_s, cont_s, hlast_s, bp_match_s;

    assign hlast_s    = (hcnt_q == (hlen_q - 32'd1));
    assign bp_match_s = bpEnable && (pc == bpAddr) && !mask_q;

    // phase/mode sequencing, half-period and burst counters
    always_comb begin
        phase_d = phase_q;
        mode_d  = mode_q;
        hcnt_d  = hcnt_q;
        hlen_d  = hlen_q;
        rem_d   = rem_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        start_s = 1'b0;
        cont_s  = 1'b0;
        case (phase_q)
            PH_OFF: begin
                if (mode_q == MODE_BRK) begin
                    // leaving BRK needs a fresh run edge; the first cycle ignores the breakpoint
                    if (run_up_s) begin
                        mode_d = MODE_RUN; mask_d = 1'b1; start_s = 1'b1;
                    end else if (burst_rise_s && (burstLen != 8'd0)) begin
                        mode_d = MODE_BURST; rem_d = burstLen; mask_d = 1'b1; start_s = 1'b1;
                    end else if (step_rise_s) begin
                        start_s = 1'b1;
                    end else begin
                        start_s = 1'b0;
                    end
                end else begin
                    if (run) begin
                        mode_d = MODE_RUN; start_s = 1'b1;
                    end else if (burst_rise_s && (burstLen != 8'd0)) begin
                        mode_d = MODE_BURST; rem_d = burstLen; start_s = 1'b1;
                    end else if (step_rise_s) begin
                        mode_d = MODE_IDLE; start_s = 1'b1;
                    end else begin
                        mode_d = MODE_IDLE;
                    end
                end
                if (start_s) begin
                    phase_d = PH_HIGH;
                    hcnt_d  = 32'd0;
                    hlen_d  = half_len(SHIFT_W, devide);
                end else begin
                    phase_d = PH_OFF;
                end
            end
            PH_HIGH: begin
                if (hlast_s) begin
                    phase_d = PH_LOW;
                    hcnt_d  = 32'd0;
                end else begin
                    hcnt_d = hcnt_q + 32'd1;
                end
            end
            PH_LOW: begin
                if (hlast_s) begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    mask_d = 1'b0;
                    case (mode_q)
                        MODE_RUN: begin
                            if (run) cont_s = 1'b1;
                            else     mode_d = MODE_IDLE;
                        end
                        MODE_BURST: begin
                            rem_d = rem_q - 8'd1;
                            if (rem_q != 8'd1) cont_s = 1'b1;
                            else               mode_d = MODE_IDLE;
                        end
                        default: cont_s = 1'b0;
                    endcase
                    if (((mode_q == MODE_RUN) || (mode_q == MODE_BURST)) && bp_match_s) begin
                        mode_d = MODE_BRK;
                        cont_s = 1'b0;
                    end else begin
                        mode_d = mode_d;
                    end
                    hcnt_d = 32'd0;
                    if (cont_s) begin
                        phase_d = PH_HIGH;
                        hlen_d  = half_len(SHIFT_W, devide);
                    end else begin
                        phase_d = PH_OFF;
                    end
                end else begin
                    hcnt_d = hcnt_q + 32'd1;
                end
            end
            default: begin
                phase_d = PH_OFF;
                hcnt_d  = 32'd0;
            end
        endcase
    end

    // state and registered outputs
    always_ff @(posedge clkIn or negedge rst_n) begin
        if (!rst_n) begin
            phase_q   <= PH_OFF;
            mode_q    <= MODE_IDLE;
            hcnt_q    <= 32'd0;
            hlen_q    <= 32'd1;
            rem_q     <= 8'd0;
            mask_q    <= 1'b0;
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
            bp_hit_q  <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            mode_q    <= mode_d;
            hcnt_q    <= hcnt_d;
            hlen_q    <= hlen_d;
            rem_q     <= rem_d;
            mask_q    <= mask_d;
            cnt_q     <= cnt_d;
            clk_out_q <= (phase_d == PH_HIGH);
            bp_hit_q  <= (mode_d == MODE_BRK);
        end
    end

    assign clkOut   = clk_out_q;
    assign cycleCnt = cnt_q;
    assign mode     = mode_q;
    assign bpHit    = bp_hit_q;

endmodule
